instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end for the RV32I core. It is the producer side of the opcode and instruction word that the control unit's main decoder consumes.
- Holds the PC and issues word requests to instruction memory over a request/response interface.
- Captures the returned word in an instruction register and presents it downstream with a valid/ready handshake.
- Accepts branch/jump redirects from the execute side and flushes any in-flight fetch.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, cycles spent in WAIT without a response before the request is reissued. Legal range 2..255.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- IMEM_REQ  out  1  one-cycle fetch request strobe.
- IMEM_ADDR  out  32  fetch address (= PC); bits [1:0] always 0.
- IMEM_RVALID  in  1  response valid from instruction memory.
- IMEM_RDATA  in  32  response instruction word.
- INSTR  out  32  instruction register contents.
- OP  out  7  INSTR[6:0], opcode to the main decoder.
- PC  out  32  address of INSTR.
- PCPLUS4  out  32  PC + 4, modulo 2^32.
- INSTR_VALID  out  1  INSTR/PC valid for the consumer.
- INSTR_READY  in  1  consumer accepts the held instruction.
- REDIRECT  in  1  branch/jump taken; load PCTARGET.
- PCTARGET  in  32  redirect target address.
- FETCH_ERR  out  1  sticky: a fetch timed out.
- MISALIGN  out  1  one-cycle pulse: the last accepted redirect target had bits [1:0] != 0.

Behaviour:
- Reset (RST=1 at an edge), with priority over everything, including mid-WAIT or mid-HOLD:
  - PC=RESET_VECTOR; INSTR=32'h0000_0013 (NOP, so OP=7'b0010011).
  - State=FETCH, timeout counter=0, DISCARD=0, FETCH_ERR=0, MISALIGN=0.
  - While RST=1, IMEM_REQ=0 and INSTR_VALID=0.
- FSM states: FETCH, WAIT, HOLD.
  - IMEM_REQ = (state==FETCH) & ~RST.
  - INSTR_VALID = (state==HOLD) & ~RST.
  - IMEM_ADDR = PC register (combinational).
- FETCH: always goes to WAIT next cycle; counter cleared.
- WAIT:
  - Counter increments every cycle.
  - IMEM_RVALID=1 and DISCARD=0: INSTR <= IMEM_RDATA; go to HOLD.
  - IMEM_RVALID=1 and DISCARD=1: drop data; clear DISCARD; go to FETCH.
  - Counter reaches TIMEOUT-1 with no RVALID: set FETCH_ERR (sticky until reset); clear DISCARD; go to FETCH, reissuing the current PC.
- HOLD:
  - INSTR, PC and INSTR_VALID are stable until INSTR_READY=1.
  - On INSTR_READY=1: PC <= REDIRECT ? {PCTARGET[31:2],2'b00} : PC+4; go to FETCH.
  - REDIRECT with INSTR_READY=0 is ignored.
- REDIRECT in FETCH or WAIT:
  - PC <= {PCTARGET[31:2],2'b00} immediately; DISCARD <= 1.
  - The outstanding response is dropped when it arrives.
  - In WAIT, if REDIRECT and IMEM_RVALID coincide, the redirect wins: data dropped, DISCARD cleared, go to FETCH.
- MISALIGN: registered; high for exactly the cycle after any accepted redirect with PCTARGET[1:0] != 0.
- IMEM_RVALID outside WAIT is ignored. The memory must not answer a timed-out request after the reissue.
- Latency: request in cycle n; with a 1-cycle memory, RVALID arrives in n+1 and INSTR_VALID in n+2. Peak throughput with READY held at 1 is one instruction per 3 cycles.
- PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 @0, 32'h00A00113 @4, READY=1 -> REQ at cycles 0 and 3 (ADDR 0, 4); INSTR_VALID at cycle 2 with OP=7'b0010011, PC=0, PCPLUS4=4; PC=4 at cycle 5.
- HOLD with READY=0 for 5 cycles, then READY=1 -> INSTR/PC stable throughout; exactly one REQ, to PC+4.
- Redirect in HOLD: READY=1, REDIRECT=1, PCTARGET=32'h0000_0102 -> next IMEM_ADDR=32'h0000_0100; MISALIGN high for exactly 1 cycle.
- Redirect in WAIT together with RVALID (PCTARGET=32'h40) -> response dropped, INSTR_VALID stays 0, next REQ at 0x40.
- No RVALID for TIMEOUT=16 cycles -> FETCH_ERR=1 from the next cycle; REQ reissued to the same PC; FETCH_ERR remains 1 after a successful fetch, until RST.
- RST asserted in HOLD with PC=0x20 -> next cycle PC=RESET_VECTOR, OP=7'b0010011, INSTR_VALID=0, FETCH_ERR=0; REQ to RESET_VECTOR in the first cycle after RST drops.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch front end: holds the PC, fetches one word at a time from
// instruction memory and hands it to the decoder over a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] pctarget,
    output logic        fetch_err,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [7:0]  cnt;
    logic        discard;

    logic [31:0] target_aligned;
    logic        target_misaligned;

    assign target_aligned    = {pctarget[31:2], 2'b00};
    assign target_misaligned = |pctarget[1:0];

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its peers; blocking here would make results order-dependent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc_q      <= {RESET_VECTOR[31:2], 2'b00};
            instr_q   <= NOP;
            cnt       <= '0;
            discard   <= 1'b0;
            fetch_err <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                S_FETCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                    // The request leaving this cycle is for the old PC; mark it stale.
                    if (redirect) begin
                        pc_q     <= target_aligned;
                        discard  <= 1'b1;
                        misalign <= target_misaligned;
                    end
                end

                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (redirect) begin
                        pc_q     <= target_aligned;
                        misalign <= target_misaligned;
                    end
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (redirect || discard) begin
                            state <= S_FETCH;
                        end else begin
                            instr_q <= imem_rdata;
                            state   <= S_HOLD;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Memory will never answer the abandoned request, so nothing is left to drop.
                        fetch_err <= 1'b1;
                        discard   <= 1'b0;
                        state     <= S_FETCH;
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (instr_ready) begin
                        pc_q     <= redirect ? target_aligned : pc_q + 32'd4;
                        misalign <= redirect & target_misaligned;
                        state    <= S_FETCH;
                    end
                end

                default: state <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = (state == S_FETCH) & ~rst;
    assign instr_valid = (state == S_HOLD) & ~rst;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pcplus4     = pc_q + 32'd4;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a randomized
// run scored against a program-order model of which PC each delivered instruction must carry.
module tb_instr_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pctarget = '0;
    logic        fetch_err;
    logic        misalign;

    // Memory response is the OR of an automatic responder and hand-driven directed stimulus.
    logic        man_rv = 1'b0;
    logic [31:0] man_rd = '0;
    logic        auto_rv = 1'b0;
    logic [31:0] auto_rd = '0;
    logic        mem_auto = 1'b0;
    logic        mem_rand = 1'b0;
    int          never_cnt = 0;

    logic        rnd_on = 1'b0;
    logic [31:0] exp_q[$];
    int          n_deliv = 0;

    int n_checks = 0;
    int n_errors = 0;

    assign imem_rvalid = man_rv | auto_rv;
    assign imem_rdata  = auto_rv ? auto_rd : man_rd;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .pc(pc), .pcplus4(pcplus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .pctarget(pctarget),
        .fetch_err(fetch_err), .misalign(misalign)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Memory: answers each request after a latency (1 cycle, or 1..4 / never when randomized).
    initial begin
        logic        pend = 1'b0;
        logic [31:0] paddr = '0;
        int          pcnt = 0;
        logic        saw;
        logic        in_rst;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            saw    = imem_req && mem_auto;
            a      = imem_addr;
            in_rst = rst;
            @(posedge clk);
            #1;
            auto_rv = 1'b0;
            if (in_rst) pend = 1'b0;
            if (saw) begin
                pend  = 1'b1;
                paddr = a;
                if (mem_rand && $urandom_range(0, 19) == 0) begin
                    pcnt = 0;
                    never_cnt++;
                end else begin
                    pcnt = mem_rand ? int'($urandom_range(1, 4)) : 1;
                end
            end
            if (pend && pcnt != 0) begin
                if (pcnt == 1) begin
                    auto_rv = 1'b1;
                    auto_rd = memf(paddr);
                    pend    = 1'b0;
                end else begin
                    pcnt--;
                end
            end
        end
    end

    // Program-order model: the next instruction's PC follows the last accepted redirect, else PC+4.
    initial begin
        logic        started = 1'b0;
        logic [31:0] model_pc = RV;
        forever begin
            @(negedge clk);
            if (!rnd_on) begin
                started = 1'b0;
            end else begin
                if (!started) begin
                    exp_q.delete();
                    model_pc = RV;
                    exp_q.push_back(model_pc);
                    started = 1'b1;
                end
                if (instr_valid && instr_ready) begin
                    model_pc = redirect ? {pctarget[31:2], 2'b00} : model_pc + 32'd4;
                    exp_q.push_back(model_pc);
                end else if (redirect) begin
                    model_pc = {pctarget[31:2], 2'b00};
                    if (exp_q.size() != 0) exp_q[exp_q.size() - 1] = model_pc;
                end
            end
        end
    end

    // Monitor: pops an expectation at the start of each presentation and checks it while held.
    initial begin
        logic        prev_valid = 1'b0;
        logic        prev_redir = 1'b0;
        logic [31:0] prev_tgt = '0;
        logic [31:0] cur_pc = '0;
        logic [31:0] cur_in;
        int          idle = 0;
        forever begin
            @(negedge clk);
            if (!rnd_on) begin
                prev_valid = 1'b0;
                prev_redir = 1'b0;
                idle       = 0;
            end else begin
                check("rnd_misalign", misalign, prev_redir && (prev_tgt[1:0] != 2'b00));
                if (imem_req) check("rnd_addr_lsbs", imem_addr[1:0], 32'd0);
                if (instr_valid) begin
                    if (!prev_valid) begin
                        idle = 0;
                        n_deliv++;
                        check("rnd_expect_pending", exp_q.size() != 0, 32'd1);
                        cur_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    end
                    cur_in = memf(cur_pc);
                    check("rnd_pc", pc, cur_pc);
                    check("rnd_instr", instr, cur_in);
                    check("rnd_op", op, cur_in[6:0]);
                    check("rnd_pcplus4", pcplus4, cur_pc + 32'd4);
                    check("rnd_fetch_err", fetch_err, never_cnt != 0);
                end else begin
                    idle++;
                    if (idle == 150) check("rnd_idle_cycles", idle, 32'd0);
                end
                prev_valid = instr_valid;
                prev_redir = redirect;
                prev_tgt   = pctarget;
            end
        end
    end

    initial begin
        int req_seen;
        repeat (3) tick();
        mem_auto    = 1'b1;
        instr_ready = 1'b1;
        sample();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, RV);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_op", op, 7'b0010011);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_misalign", misalign, 0);

        // Back-to-back fetches from a 1-cycle memory.
        tick(); rst = 1'b0; sample();
        check("c0_req", imem_req, 1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", instr_valid, 0);
        tick(); sample();
        check("c1_req", imem_req, 0);
        check("c1_valid", instr_valid, 0);
        tick(); sample();
        check("c2_valid", instr_valid, 1);
        check("c2_instr", instr, 32'h0050_0093);
        check("c2_op", op, 7'b0010011);
        check("c2_pc", pc, 32'h0);
        check("c2_pcplus4", pcplus4, 32'h4);
        tick(); sample();
        check("c3_req", imem_req, 1);
        check("c3_addr", imem_addr, 32'h4);
        tick();
        tick(); instr_ready = 1'b0;

        // Consumer stalls for five cycles.
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("stall_valid", instr_valid, 1);
            check("stall_pc", pc, 32'h4);
            check("stall_instr", instr, 32'h00A0_0113);
            req_seen += int'(imem_req);
            tick();
        end
        instr_ready = 1'b1;
        sample();
        req_seen += int'(imem_req);
        tick(); sample();
        check("after_stall_req", imem_req, 1);
        check("after_stall_addr", imem_addr, 32'h8);
        req_seen += int'(imem_req);
        tick(); sample();
        req_seen += int'(imem_req);

        // Misaligned redirect taken while holding.
        tick(); redirect = 1'b1; pctarget = 32'h0000_0102; sample();
        check("stall_req_count", req_seen, 1);
        check("hold8_pc", pc, 32'h8);
        check("hold8_instr", instr, memf(32'h8));
        tick(); redirect = 1'b0; sample();
        check("redir_hold_addr", imem_addr, 32'h100);
        check("redir_hold_req", imem_req, 1);
        check("redir_hold_misalign", misalign, 1);
        tick(); sample();
        check("misalign_one_cycle", misalign, 0);
        tick(); mem_auto = 1'b0; sample();
        check("hold100_pc", pc, 32'h100);

        // Redirect coinciding with a response in WAIT.
        tick(); instr_ready = 1'b0; sample();
        check("c17_addr", imem_addr, 32'h104);
        tick(); man_rv = 1'b1; man_rd = 32'h0000_0033; redirect = 1'b1; pctarget = 32'h40; sample();
        check("wait_redir_valid", instr_valid, 0);
        tick(); man_rv = 1'b0; redirect = 1'b0; sample();
        check("wait_redir_req", imem_req, 1);
        check("wait_redir_addr", imem_addr, 32'h40);
        check("wait_redir_drop", instr_valid, 0);
        check("wait_redir_misalign", misalign, 0);
        tick(); man_rv = 1'b1; man_rd = 32'h0040_0113; sample();
        check("c20_valid", instr_valid, 0);
        tick(); man_rv = 1'b0; redirect = 1'b1; pctarget = 32'h200; sample();
        check("c21_pc", pc, 32'h40);
        check("c21_instr", instr, 32'h0040_0113);

        // Redirect without READY in HOLD has no effect.
        tick(); redirect = 1'b0; instr_ready = 1'b1; sample();
        check("ignored_redir_pc", pc, 32'h40);
        check("ignored_redir_valid", instr_valid, 1);
        check("ignored_redir_misalign", misalign, 0);
        tick(); instr_ready = 1'b0; sample();
        check("c23_addr", imem_addr, 32'h44);
        check("c23_fetch_err", fetch_err, 0);

        // No response: timeout after TO cycles in WAIT, then reissue.
        req_seen = 0;
        for (int i = 0; i < TO; i++) begin
            tick(); sample();
            req_seen += int'(imem_req);
        end
        check("timeout_no_req", req_seen, 0);
        check("timeout_err_before", fetch_err, 0);
        tick(); sample();
        check("timeout_err_set", fetch_err, 1);
        check("timeout_reissue_req", imem_req, 1);
        check("timeout_reissue_addr", imem_addr, 32'h44);
        tick(); man_rv = 1'b1; man_rd = 32'h0000_1037; sample();
        tick(); man_rv = 1'b0; instr_ready = 1'b1; redirect = 1'b1; pctarget = 32'h20; sample();
        check("post_to_pc", pc, 32'h44);
        check("post_to_op", op, 7'b0110111);
        check("post_to_err_sticky", fetch_err, 1);
        tick(); redirect = 1'b0; instr_ready = 1'b0; sample();
        check("c43_addr", imem_addr, 32'h20);
        tick(); man_rv = 1'b1; man_rd = 32'h0000_0063; sample();

        // Reset while holding PC 0x20.
        tick(); man_rv = 1'b0; rst = 1'b1; sample();
        check("rst_hold_pc", pc, 32'h20);
        check("rst_hold_valid", instr_valid, 0);
        tick(); sample();
        check("rst2_pc", pc, RV);
        check("rst2_op", op, 7'b0010011);
        check("rst2_valid", instr_valid, 0);
        check("rst2_fetch_err", fetch_err, 0);
        check("rst2_req", imem_req, 0);
        tick(); rst = 1'b0; sample();
        check("rst_rel_req", imem_req, 1);
        check("rst_rel_addr", imem_addr, RV);

        // Randomized run.
        tick(); rst = 1'b1;
        tick(); mem_auto = 1'b1; mem_rand = 1'b1; instr_ready = 1'b0;
        tick(); rst = 1'b0; rnd_on = 1'b1; redirect = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            redirect    = ($urandom_range(0, 9) == 0);
            instr_ready = redirect ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (redirect)
                pctarget = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom();
        end
        tick(); rnd_on = 1'b0; redirect = 1'b0; instr_ready = 1'b1; mem_rand = 1'b0;
        repeat (TO + 8) tick();
        sample();
        check("rnd_deliveries_min", n_deliv >= 100, 1);
        check("rnd_fetch_err_final", fetch_err, never_cnt != 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
